jt51_lin2log: RTL and testbench

- Linear-to-log converter: the reverse of the exponential lookup that turns log-domain attenuation into linear amplitude.
- Takes an unsigned linear magnitude and returns a fixed-point base-2 logarithm: integer part from MSB position, fractional part from a 32-entry registered ROM.
- Sits beside the operator/envelope path for level metering, feedback analysis and test-bench round-trip checks against the exp path.
- 3-stage pipeline with valid/ready handshake on both sides.

---
 rtl/jt51_lin2log_pkg.sv | 25 ++
 rtl/jt51_logrom.sv | 24 ++
 rtl/jt51_lin2log.sv | 102 ++++++++++
 tb/tb_jt51_lin2log.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_lin2log_pkg.sv
// Shared constants for the linear-to-log converter: fraction table and the
// leading-one locator used by both the RTL and reference models.
package jt51_lin2log_pkg;

  localparam int LOG_FW = 8;
  localparam int LUT_AW = 5;

  // LOG_LUT[k] = round(256 * log2(1 + k/32))
  localparam logic [LOG_FW-1:0] LOG_LUT [0:31] = '{
    8'd0,   8'd11,  8'd22,  8'd33,  8'd44,  8'd54,  8'd63,  8'd73,
    8'd82,  8'd92,  8'd100, 8'd109, 8'd118, 8'd126, 8'd134, 8'd142,
    8'd150, 8'd157, 8'd165, 8'd172, 8'd179, 8'd186, 8'd193, 8'd200,
    8'd207, 8'd213, 8'd220, 8'd226, 8'd232, 8'd238, 8'd244, 8'd250
  };

  function automatic logic [3:0] msb_pos(input logic [15:0] x);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) p = 4'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/jt51_logrom.sv
// Registered 32x8 log2 fraction ROM; output only advances when en is high.
module jt51_logrom
  import jt51_lin2log_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [LOG_FW-1:0] data
);

  logic [LOG_FW-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = LOG_LUT[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/jt51_lin2log.sv
// Three-stage linear magnitude to 256*log2(x) converter with a global-stall
// valid/ready pipeline.
module jt51_lin2log
  import jt51_lin2log_pkg::*;
#(
  parameter int IW = 13,
  parameter int EW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] lin_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW+7:0] log_out,
  output logic          zero_out
);

  logic              en;
  logic              vld_p1_q, vld_p1_d;
  logic [IW-1:0]     lin_p1_q, lin_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [EW-1:0]     msb_p2_q, msb_p2_d;
  logic [LUT_AW-1:0] addr_p2_q, addr_p2_d;
  logic              zero_p2_q, zero_p2_d;
  logic              vld_p3_q, vld_p3_d;
  logic [EW-1:0]     msb_p3_q, msb_p3_d;
  logic              zero_p3_q, zero_p3_d;
  logic [LOG_FW-1:0] frac_p3;
  logic [3:0]        msb_raw;
  logic [LUT_AW-1:0] mant;

  always_comb begin
    en        = !vld_p3_q || out_ready;
    msb_raw   = msb_pos(16'(lin_p1_q));
    // Shifting the value right by its MSB index leaves the bits just below
    // the leading one in the low LUT_AW positions, zero-padded when short.
    mant      = LUT_AW'({lin_p1_q, {LUT_AW{1'b0}}} >> msb_raw);
    vld_p1_d  = vld_p1_q;
    lin_p1_d  = lin_p1_q;
    vld_p2_d  = vld_p2_q;
    msb_p2_d  = msb_p2_q;
    addr_p2_d = addr_p2_q;
    zero_p2_d = zero_p2_q;
    vld_p3_d  = vld_p3_q;
    msb_p3_d  = msb_p3_q;
    zero_p3_d = zero_p3_q;
    if (en) begin
      // stage 1: capture input
      vld_p1_d  = in_valid;
      lin_p1_d  = lin_in;
      // stage 2: leading-one position and table address
      vld_p2_d  = vld_p1_q;
      msb_p2_d  = EW'(msb_raw);
      addr_p2_d = mant;
      zero_p2_d = (lin_p1_q == '0);
      // stage 3: align with the registered ROM read
      vld_p3_d  = vld_p2_q;
      msb_p3_d  = msb_p2_q;
      zero_p3_d = zero_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      lin_p1_q  <= '0;
      vld_p2_q  <= 1'b0;
      msb_p2_q  <= '0;
      addr_p2_q <= '0;
      zero_p2_q <= 1'b0;
      vld_p3_q  <= 1'b0;
      msb_p3_q  <= '0;
      zero_p3_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      lin_p1_q  <= lin_p1_d;
      vld_p2_q  <= vld_p2_d;
      msb_p2_q  <= msb_p2_d;
      addr_p2_q <= addr_p2_d;
      zero_p2_q <= zero_p2_d;
      vld_p3_q  <= vld_p3_d;
      msb_p3_q  <= msb_p3_d;
      zero_p3_q <= zero_p3_d;
    end
  end

  jt51_logrom u_rom (
    .clk  (clk),
    .en   (en),
    .addr (addr_p2_q),
    .data (frac_p3)
  );

  // The ROM has no reset, so the result is masked while no sample is held.
  assign log_out   = (vld_p3_q && !zero_p3_q) ? {msb_p3_q, frac_p3} : '0;
  assign zero_out  = zero_p3_q;
  assign out_valid = vld_p3_q;
  assign in_ready  = en;

endmodule

// File: tb/tb_jt51_lin2log.sv
// Directed and random bench for jt51_lin2log with an in-order scoreboard.
module tb_jt51_lin2log;
  import jt51_lin2log_pkg::*;

  localparam int IW = 13;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW-1:0] lin_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [EW+7:0] log_out;
  logic          zero_out;

  jt51_lin2log #(.IW(IW), .EW(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lin_in    (lin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .log_out   (log_out),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int recv = 0;
  logic [7:0]    ref_lut [0:31];
  logic [EW+8:0] expq [$];
  logic [EW+8:0] exp_e;
  logic          sweep_on = 1'b0;
  logic [EW+7:0] prev_mono = '0;
  logic          prev_stall = 1'b0;
  logic [EW+7:0] prev_log = '0;
  logic          prev_zero = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Reference result {zero, log}: mantissa bits taken arithmetically.
  function automatic logic [EW+8:0] model(input logic [IW-1:0] x);
    int m;
    int xi;
    int a;
    m  = 0;
    xi = int'(x);
    if (xi == 0) return {1'b1, {(EW+8){1'b0}}};
    for (int i = 0; i < IW; i++) if (xi >= (1 << i)) m = i;
    if (m >= 5) a = (xi >> (m - 5)) & 31;
    else        a = (xi << (5 - m)) & 31;
    return {1'b0, EW'(m), ref_lut[a]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_vld", 32'(out_valid), 1);
        check_eq("hold_log", 32'(log_out), 32'(prev_log));
        check_eq("hold_zero", 32'(zero_out), 32'(prev_zero));
      end
      check_eq("ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        recv++;
        if (expq.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 0);
        end else begin
          exp_e = expq.pop_front();
          check_eq("sb_log", 32'(log_out), 32'(exp_e[EW+7:0]));
          check_eq("sb_zero", 32'(zero_out), 32'(exp_e[EW+8]));
        end
        if (sweep_on) begin
          check_eq("monotonic", 32'(log_out >= prev_mono), 1);
          prev_mono = log_out;
        end
      end
      if (in_valid && in_ready) expq.push_back(model(lin_in));
      prev_stall = out_valid && !out_ready;
      prev_log   = log_out;
      prev_zero  = zero_out;
    end
  end

  initial begin
    logic [IW-1:0] dv [6];
    logic [11:0]   de [6];
    logic          dz [6];
    int sent;
    int r0;
    int n;
    real r;

    dv = '{13'd1, 13'd4096, 13'd6144, 13'd8191, 13'd3, 13'd0};
    de = '{12'h000, 12'hC00, 12'hC96, 12'hCFA, 12'h196, 12'h000};
    dz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 32; k++) begin
      r = 256.0 * $ln(1.0 + k / 32.0) / $ln(2.0);
      ref_lut[k] = 8'($rtoi(r + 0.5));
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_log_out", 32'(log_out), 0);
    check_eq("rst_zero_out", 32'(zero_out), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors, latency and hand-computed values
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b0;
      lin_in   = '0;
      if (c < 6) begin
        in_valid = 1'b1;
        lin_in   = dv[c];
      end
      @(posedge clk);
      #1;
      if (c >= 2 && c < 8) begin
        check_eq("dir_valid", 32'(out_valid), 1);
        check_eq("dir_log", 32'(log_out), 32'(de[c-2]));
        check_eq("dir_zero", 32'(zero_out), 32'(dz[c-2]));
      end else begin
        check_eq("dir_idle", 32'(out_valid), 0);
      end
    end

    // stall window with 10 streamed samples
    sent = 0;
    r0   = recv;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 10);
      lin_in    = IW'(700 * sent + 5);
      #1;
      if (cyc >= 4 && cyc <= 8) check_eq("stall_in_ready", 32'(in_ready), 0);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    check_eq("stall_sent", sent, 10);
    check_eq("stall_recv", recv - r0, 10);
    check_eq("stall_queue", expq.size(), 0);

    // full sweep
    out_ready = 1'b1;
    prev_mono = '0;
    sweep_on  = 1'b1;
    r0        = recv;
    for (int x = 1; x < (1 << IW); x++) begin
      in_valid = 1'b1;
      lin_in   = IW'(x);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sweep_on = 1'b0;
    check_eq("sweep_recv", recv - r0, (1 << IW) - 1);

    // asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      lin_in   = IW'(500 + i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("flight_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 0);
    check_eq("arst_log_out", 32'(log_out), 0);
    expq.delete();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_idle", 32'(out_valid), 0);
    end

    // random handshake traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      lin_in    = IW'($urandom_range(0, (1 << IW) - 1));
      if ($urandom_range(0, 15) == 0) lin_in = '0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_queue", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
